// File: rtl/bs_prod_deser_pkg.sv
// rtl/bs_prod_deser_pkg.sv - shared FSM encodings and default width for the bit-serial product path
package bs_prod_deser_pkg;

  // Frame FSM: ACC assembles bits, DISCARD swallows the tail of an over-long frame
  localparam logic BS_ST_ACC     = 1'b0;
  localparam logic BS_ST_DISCARD = 1'b1;

  // Default product width (2 x operand width of the multiplier array)
  localparam int   BS_PW         = 32;

endpackage

// File: rtl/bs_prod_deser.sv
// rtl/bs_prod_deser.sv - serial product deserializer with held output and sticky errors; optional BS_DESER_STATS_EN adds nprod/nerr counters
module bs_prod_deser
  import bs_prod_deser_pkg::*;
#(
  parameter int PW = BS_PW,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pbit,
  input  logic          pvld,
  input  logic          lastbit,
  output logic [PW-1:0] prod,
  output logic          prod_valid,
  input  logic          prod_ready,
  input  logic          err_clr,
  output logic          ferr,
  output logic          ovf
`ifdef BS_DESER_STATS_EN
  ,
  output logic [15:0]   nprod,
  output logic [7:0]    nerr
`endif
);

  localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

  logic          state;
  logic [CW-1:0] cnt;
  // Upper PW-1 bits of the word in flight; the incoming bit completes it
  logic [PW-2:0] sr;
  logic [PW-1:0] word;

  logic acc_bit;
  logic at_last;
  logic good_f;
  logic short_f;
  logic long_f;
  logic accept;
  logic load;
  logic drop_ovf;

  assign word     = {pbit, sr};
  assign acc_bit  = pvld && (state == BS_ST_ACC);
  assign at_last  = (cnt == CNT_LAST);
  assign good_f   = acc_bit && lastbit && at_last;
  assign short_f  = acc_bit && lastbit && !at_last;
  assign long_f   = acc_bit && !lastbit && at_last;
  assign accept   = prod_valid && prod_ready;
  // A finished word may replace the held one only if the slot is free or being emptied now
  assign load     = good_f && (!prod_valid || prod_ready);
  assign drop_ovf = good_f && !load;

  // Frame FSM and bit counter: every frame end (good, short or long) restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BS_ST_ACC;
      cnt   <= '0;
    end else if (pvld) begin
      if (state == BS_ST_ACC) begin
        if (lastbit || at_last) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        if (long_f) begin
          state <= BS_ST_DISCARD;
        end
      end else if (lastbit) begin
        state <= BS_ST_ACC;
        cnt   <= '0;
      end
    end
  end

  // Shift register: LSB arrives first, so new bits enter at the top and move down
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (acc_bit) begin
      sr <= word[PW-1:1];
    end
  end

  // Output hold register: load a finished word, otherwise drop valid only on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
    end else if (load) begin
      prod       <= word;
      prod_valid <= 1'b1;
    end else if (accept) begin
      prod_valid <= 1'b0;
    end
  end

  // Sticky error flags: a new error event takes priority over err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      ferr <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (short_f || long_f) begin
        ferr <= 1'b1;
      end else if (err_clr) begin
        ferr <= 1'b0;
      end
      if (drop_ovf) begin
        ovf <= 1'b1;
      end else if (err_clr) begin
        ovf <= 1'b0;
      end
    end
  end

`ifdef BS_DESER_STATS_EN
  // Saturating statistics; deliberately untouched by err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      nprod <= '0;
      nerr  <= '0;
    end else begin
      if (accept && (nprod != '1)) begin
        nprod <= nprod + 1'b1;
      end
      if ((short_f || long_f || drop_ovf) && (nerr != '1)) begin
        nerr <= nerr + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bs_prod_deser.sv
// tb/tb_bs_prod_deser.sv - scoreboard bench for bs_prod_deser at PW=8 (BS_DESER_STATS_EN optional)
module tb_bs_prod_deser;

  logic       clk;
  logic       rst;
  logic       pbit;
  logic       pvld;
  logic       lastbit;
  logic [7:0] prod;
  logic       prod_valid;
  logic       prod_ready;
  logic       err_clr;
  logic       ferr;
  logic       ovf;
`ifdef BS_DESER_STATS_EN
  logic [15:0] nprod;
  logic [7:0]  nerr;
`endif

  int n_vec;
  int n_err;
  logic [7:0] sb[$];

  bs_prod_deser #(.PW(8), .CW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .pbit       (pbit),
    .pvld       (pvld),
    .lastbit    (lastbit),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .err_clr    (err_clr),
    .ferr       (ferr),
    .ovf        (ovf)
`ifdef BS_DESER_STATS_EN
    ,
    .nprod      (nprod),
    .nerr       (nerr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every handshake must deliver the oldest expected product
  always @(negedge clk) begin
    if (prod_valid && prod_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got prod=%h, expected no product", prod);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (prod !== e) begin
          n_err++;
          $display("FAIL sb_prod: got %h, expected %h", prod, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pvld    = 1'b0;
      lastbit = 1'b0;
      err_clr = 1'b0;
    end
  endtask

  // Drives nbits bits LSB first, lastbit on the final one; leaves the final bit on the pins
  task automatic send_frame(input logic [15:0] val, input int nbits, input bit gaps,
                            input bit clr_last, input bit rdy_last);
    logic [15:0] v;
    v = val;
    for (int i = 0; i < nbits; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          pvld    = 1'b0;
          pbit    = 1'($urandom_range(0, 1));
          lastbit = 1'($urandom_range(0, 1));
        end
      end
      @(posedge clk); #1;
      pvld    = 1'b1;
      pbit    = v[i];
      lastbit = (i == nbits - 1);
      err_clr = clr_last && (i == nbits - 1);
      if (rdy_last && (i == nbits - 1)) prod_ready = 1'b1;
    end
  endtask

  task automatic pulse_clr;
    @(posedge clk); #1; err_clr = 1'b1; pvld = 1'b0;
    @(posedge clk); #1; err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; pvld = 1'b0; pbit = 1'b0; lastbit = 1'b0; prod_ready = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({prod, prod_valid, ferr, ovf} !== 11'h0) begin
      n_err++;
      $display("FAIL reset_state: got prod=%h v=%b ferr=%b ovf=%b, expected all 0", prod, prod_valid, ferr, ovf);
    end
  endtask

  task automatic test_single;
    sb.push_back(8'h4D);
    send_frame(16'h004D, 8, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++;
    if (prod_valid !== 1'b0) begin
      n_err++; $display("FAIL single_early: got prod_valid=%b, expected 0", prod_valid);
    end
    idle(1);
    @(negedge clk);
    n_vec++;
    if (prod_valid !== 1'b1 || prod !== 8'h4D) begin
      n_err++; $display("FAIL single_latency: got v=%b prod=%h, expected v=1 prod=4d", prod_valid, prod);
    end
    idle(2);
    n_vec++;
    if (ferr !== 1'b0 || ovf !== 1'b0 || sb.size() != 0) begin
      n_err++; $display("FAIL single_flags: got ferr=%b ovf=%b pending=%0d, expected 0 0 0", ferr, ovf, sb.size());
    end
  endtask

  task automatic test_overflow;
    prod_ready = 1'b0;
    sb.push_back(8'hFF);
    send_frame(16'h00FF, 8, 1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(16'h0001, 8, 1'b1, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    n_vec++;
    if (prod !== 8'hFF || prod_valid !== 1'b1 || ovf !== 1'b1 || ferr !== 1'b0) begin
      n_err++; $display("FAIL ovf_hold: got prod=%h v=%b ovf=%b ferr=%b, expected ff 1 1 0", prod, prod_valid, ovf, ferr);
    end
    @(posedge clk); #1 prod_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (prod_valid !== 1'b0 || sb.size() != 0) begin
      n_err++; $display("FAIL ovf_accept: got v=%b pending=%0d, expected 0 0", prod_valid, sb.size());
    end
    pulse_clr();
    @(negedge clk);
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++; $display("FAIL ovf_clr: got ovf=%b, expected 0", ovf);
    end
  endtask

  task automatic test_accept_and_load;
    prod_ready = 1'b0;
    sb.push_back(8'h5A);
    send_frame(16'h005A, 8, 1'b0, 1'b0, 1'b0);
    idle(2);
    sb.push_back(8'hC3);
    send_frame(16'h00C3, 8, 1'b0, 1'b0, 1'b1);
    idle(3);
    @(negedge clk);
    n_vec++;
    if (ovf !== 1'b0 || prod_valid !== 1'b0 || sb.size() != 0) begin
      n_err++; $display("FAIL accept_load: got ovf=%b v=%b pending=%0d, expected 0 0 0", ovf, prod_valid, sb.size());
    end
  endtask

  task automatic test_short;
    send_frame(16'h0015, 5, 1'b0, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    n_vec++;
    if (ferr !== 1'b1 || prod_valid !== 1'b0) begin
      n_err++; $display("FAIL short_frame: got ferr=%b v=%b, expected 1 0", ferr, prod_valid);
    end
    sb.push_back(8'hA5);
    send_frame(16'h00A5, 8, 1'b1, 1'b0, 1'b0);
    idle(3);
    n_vec++;
    if (sb.size() != 0 || prod !== 8'hA5) begin
      n_err++; $display("FAIL short_next: got prod=%h pending=%0d, expected a5 0", prod, sb.size());
    end
  endtask

  task automatic test_long;
    pulse_clr();
    send_frame(16'h05AB, 11, 1'b0, 1'b0, 1'b0);
    idle(2);
    @(negedge clk);
    n_vec++;
    if (ferr !== 1'b1 || prod_valid !== 1'b0) begin
      n_err++; $display("FAIL long_frame: got ferr=%b v=%b, expected 1 0", ferr, prod_valid);
    end
    sb.push_back(8'h3C);
    send_frame(16'h003C, 8, 1'b0, 1'b0, 1'b0);
    idle(3);
    n_vec++;
    if (sb.size() != 0 || prod !== 8'h3C) begin
      n_err++; $display("FAIL long_next: got prod=%h pending=%0d, expected 3c 0", prod, sb.size());
    end
  endtask

  task automatic test_reset_mid_and_clr;
    repeat (4) begin
      @(posedge clk); #1; pvld = 1'b1; pbit = 1'b1; lastbit = 1'b0;
    end
    @(posedge clk); #1; pvld = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    sb.push_back(8'h81);
    send_frame(16'h0081, 8, 1'b0, 1'b0, 1'b0);
    idle(3);
    @(negedge clk);
    n_vec++;
    if (ferr !== 1'b0 || prod !== 8'h81 || sb.size() != 0) begin
      n_err++; $display("FAIL rst_mid: got ferr=%b prod=%h pending=%0d, expected 0 81 0", ferr, prod, sb.size());
    end
    send_frame(16'h0003, 3, 1'b0, 1'b0, 1'b0);
    idle(1);
    pulse_clr();
    @(negedge clk);
    n_vec++;
    if (ferr !== 1'b0) begin
      n_err++; $display("FAIL err_clr: got ferr=%b, expected 0", ferr);
    end
    send_frame(16'h0002, 2, 1'b0, 1'b1, 1'b0);
    idle(1);
    @(negedge clk);
    n_vec++;
    if (ferr !== 1'b1) begin
      n_err++; $display("FAIL clr_vs_set: got ferr=%b, expected 1", ferr);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      sb.push_back(v);
      send_frame({8'h00, v}, 8, (i >= 2), 1'b0, 1'b0);
    end
    idle(3);
    n_vec++;
    if (sb.size() != 0 || prod_valid !== 1'b0) begin
      n_err++; $display("FAIL back_to_back: got pending=%0d v=%b, expected 0 0", sb.size(), prod_valid);
    end
  endtask

`ifdef BS_DESER_STATS_EN
  task automatic test_stats;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (nprod !== 16'd0 || nerr !== 8'd0) begin
      n_err++; $display("FAIL stats_reset: got nprod=%0d nerr=%0d, expected 0 0", nprod, nerr);
    end
    for (int i = 0; i < 3; i++) begin
      sb.push_back(8'h11 * 8'(i + 1));
      send_frame({8'h00, 8'h11 * 8'(i + 1)}, 8, 1'b1, 1'b0, 1'b0);
    end
    send_frame(16'h0007, 4, 1'b1, 1'b0, 1'b0);
    idle(3);
    pulse_clr();
    @(negedge clk);
    n_vec++;
    if (nprod !== 16'd3 || nerr !== 8'd1 || sb.size() != 0) begin
      n_err++; $display("FAIL stats_count: got nprod=%0d nerr=%0d pending=%0d, expected 3 1 0", nprod, nerr, sb.size());
    end
  endtask
`endif

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_overflow();
    test_accept_and_load();
    test_short();
    test_long();
    test_reset_mid_and_clr();
    test_back_to_back();
`ifdef BS_DESER_STATS_EN
    test_stats();
`endif
    idle(2);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_drain: got %0d pending products, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
